// File: rtl/demux_deser4_pkg.sv
// demux_deser4_pkg: shared constants, FSM state type and lane-to-bit mapping
// for the demux_deser4 serial-to-parallel deserializer.
package demux_deser4_pkg;

  localparam int LANES = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    HUNT,
    ASSEMBLE
  } state_e;

  // Bit position in the output word that a given lane occupies.
  function automatic logic [SEL_W-1:0] lane_bit(input logic [SEL_W-1:0] lane,
                                                input logic             msb_first);
    return msb_first ? (SEL_W'(LANES - 1) - lane) : lane;
  endfunction

endpackage

// File: rtl/demux_beat_ctr.sv
// demux_beat_ctr: lane counter with wrap and sync-abort decisions for demux_deser4.
// With DEMUX_DESER4_PARITY_EN defined, an extra parity phase follows lane 3.
module demux_beat_ctr
  import demux_deser4_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             beat_i,
  input  logic             sync_i,
  output logic [SEL_W-1:0] sel_o,
  output logic [SEL_W-1:0] lane_o,
  output logic             wr_o,
  output logic             abort_o,
  output logic             done_o
);

  logic [SEL_W-1:0] sel_q, sel_d;
  logic             last_lane;

  assign last_lane = (sel_q == SEL_W'(LANES - 1));
  assign sel_o     = sel_q;

`ifdef DEMUX_DESER4_PARITY_EN
  logic phase_q, phase_d;

  // A sync during the parity phase is mid-frame, so it aborts like any other.
  always_comb begin
    sel_d   = sel_q;
    phase_d = phase_q;
    abort_o = beat_i && sync_i && ((sel_q != '0) || phase_q);
    wr_o    = beat_i && (abort_o || !phase_q);
    done_o  = beat_i && phase_q && !sync_i;
    lane_o  = abort_o ? '0 : sel_q;
    if (abort_o) begin
      sel_d   = SEL_W'(1);
      phase_d = 1'b0;
    end else if (beat_i) begin
      if (phase_q) begin
        phase_d = 1'b0;
      end else if (last_lane) begin
        sel_d   = '0;
        phase_d = 1'b1;
      end else begin
        sel_d = sel_q + SEL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      phase_q <= phase_d;
    end
  end
`else
  always_comb begin
    sel_d   = sel_q;
    abort_o = beat_i && sync_i && (sel_q != '0);
    wr_o    = beat_i;
    done_o  = beat_i && !abort_o && last_lane;
    lane_o  = abort_o ? '0 : sel_q;
    if (abort_o) begin
      sel_d = SEL_W'(1);
    end else if (beat_i) begin
      sel_d = sel_q + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= '0;
    end else begin
      sel_q <= sel_d;
    end
  end
`endif

endmodule

// File: rtl/demux_deser4.sv
// demux_deser4: 1-bit serial beats to 4-bit words, framed by sync_in.
// Define DEMUX_DESER4_PARITY_EN for a fifth even-parity beat per frame.
module demux_deser4
  import demux_deser4_pkg::*;
#(
  parameter int SYNC_REQUIRED = 1,
  parameter int MSB_FIRST     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             demux_in,
  input  logic             demux_in_valid,
  input  logic             sync_in,
  output logic [SEL_W-1:0] demux_sel,
  output logic [LANES-1:0] demux_out,
  output logic             demux_out_valid,
  output logic             frame_err,
  output logic             parity_err
);

  localparam state_e RESET_STATE = (SYNC_REQUIRED != 0) ? HUNT : ASSEMBLE;
  localparam logic   MSB_FIRST_B = (MSB_FIRST != 0);

  state_e           state_q, state_d;
  logic             beat;
  logic             lane_wr;
  logic             abort;
  logic             done;
  logic             par_ok;
  logic [SEL_W-1:0] lane;
  logic [LANES-1:0] part_q, part_d;
  logic [LANES-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  // Only a sync beat leaves HUNT; beats dropped here never reach the counter.
  always_comb begin
    state_d = state_q;
    beat    = 1'b0;
    case (state_q)
      HUNT: begin
        if (demux_in_valid && sync_in) begin
          beat    = 1'b1;
          state_d = ASSEMBLE;
        end
      end
      ASSEMBLE: beat = demux_in_valid;
      default:  state_d = RESET_STATE;
    endcase
  end

  demux_beat_ctr u_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .beat_i  (beat),
    .sync_i  (sync_in),
    .sel_o   (demux_sel),
    .lane_o  (lane),
    .wr_o    (lane_wr),
    .abort_o (abort),
    .done_o  (done)
  );

  always_comb begin
    part_d = part_q;
    if (abort) begin
      part_d = '0;
    end
    if (lane_wr) begin
      part_d[lane_bit(lane, MSB_FIRST_B)] = demux_in;
    end
  end

`ifdef DEMUX_DESER4_PARITY_EN
  // On the parity beat part_q already holds all four data lanes.
  assign par_ok = (demux_in == ^part_q);
`else
  assign par_ok = 1'b1;
`endif

  // part_d includes the beat just taken, so lane 3 lands in the word directly.
  always_comb begin
    out_d   = out_q;
    valid_d = 1'b0;
    ferr_d  = abort;
    if (done && par_ok) begin
      out_d   = part_d;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
      part_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      part_q  <= part_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign demux_out       = out_q;
  assign demux_out_valid = valid_q;
  assign frame_err       = ferr_q;

`ifdef DEMUX_DESER4_PARITY_EN
  logic perr_q, perr_d;

  assign perr_d = done && !par_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_demux_deser4.sv
// tb_demux_deser4: two instances (SYNC_REQUIRED=1/MSB_FIRST=0 and 0/1) share
// stimulus; a frame-level model predicts every output on every cycle.
module tb_demux_deser4;

`ifdef DEMUX_DESER4_PARITY_EN
  localparam int FRAME = 5;
`else
  localparam int FRAME = 4;
`endif

  logic clk;
  logic rst_n;
  logic v_in, d_in, s_in;

  logic [1:0] sel_w  [2];
  logic [3:0] out_w  [2];
  logic       val_w  [2];
  logic       ferr_w [2];
  logic       perr_w [2];

  int n_pass;
  int n_total;
  int vcount [2];
  int fcount [2];

  // Model state: beats collected for the frame in progress, per instance.
  int         m_cnt   [2];
  bit         m_sync  [2];
  logic [4:0] m_beats [2];
  logic [3:0] e_out   [2];
  logic       e_valid [2];
  logic       e_ferr  [2];
  logic       e_perr  [2];
  logic [3:0] m_word;
  logic       m_ok;
  bit         msb_cfg [2];
  bit         syncreq_cfg [2];

  demux_deser4 #(.SYNC_REQUIRED(1), .MSB_FIRST(0)) dut (
    .clk(clk), .rst_n(rst_n), .demux_in(d_in), .demux_in_valid(v_in), .sync_in(s_in),
    .demux_sel(sel_w[0]), .demux_out(out_w[0]), .demux_out_valid(val_w[0]),
    .frame_err(ferr_w[0]), .parity_err(perr_w[0])
  );

  demux_deser4 #(.SYNC_REQUIRED(0), .MSB_FIRST(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .demux_in(d_in), .demux_in_valid(v_in), .sync_in(s_in),
    .demux_sel(sel_w[1]), .demux_out(out_w[1]), .demux_out_valid(val_w[1]),
    .frame_err(ferr_w[1]), .parity_err(perr_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int k, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[dut%0d] @%0t: got %0h expected %0h", nm, k, $time, act, exp);
  endtask

  // Reference: a frame is FRAME accepted beats; sync restarts it and flags
  // an error if beats were already collected.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_cnt[k]   = 0;
        m_sync[k]  = !syncreq_cfg[k];
        e_out[k]   = 4'h0;
        e_valid[k] = 1'b0;
        e_ferr[k]  = 1'b0;
        e_perr[k]  = 1'b0;
      end else begin
        e_valid[k] = 1'b0;
        e_ferr[k]  = 1'b0;
        e_perr[k]  = 1'b0;
        if (v_in && (m_sync[k] || s_in)) begin
          if (s_in) begin
            if (m_cnt[k] != 0) e_ferr[k] = 1'b1;
            m_cnt[k]  = 0;
            m_sync[k] = 1'b1;
          end
          m_beats[k][m_cnt[k]] = d_in;
          m_cnt[k]++;
          if (m_cnt[k] == FRAME) begin
            m_word = 4'h0;
            for (int i = 0; i < 4; i++) m_word[msb_cfg[k] ? 3 - i : i] = m_beats[k][i];
            m_ok = (FRAME == 4) || (m_beats[k][4] == ^m_word);
            if (m_ok) begin
              e_out[k]   = m_word;
              e_valid[k] = 1'b1;
            end else begin
              e_perr[k] = 1'b1;
            end
            m_cnt[k] = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        check("rst_sel", k, 8'(sel_w[k]), 8'h0);
        check("rst_out", k, 8'(out_w[k]), 8'h0);
        check("rst_valid", k, 8'(val_w[k]), 8'h0);
        check("rst_ferr", k, 8'(ferr_w[k]), 8'h0);
        check("rst_perr", k, 8'(perr_w[k]), 8'h0);
      end else begin
        check("sel", k, 8'(sel_w[k]), 8'((m_cnt[k] < 4) ? m_cnt[k] : 0));
        check("out", k, 8'(out_w[k]), 8'(e_out[k]));
        check("valid", k, 8'(val_w[k]), 8'(e_valid[k]));
        check("frame_err", k, 8'(ferr_w[k]), 8'(e_ferr[k]));
        check("parity_err", k, 8'(perr_w[k]), 8'(e_perr[k]));
        if (val_w[k]) vcount[k]++;
        if (ferr_w[k]) fcount[k]++;
      end
    end
  end

  // Inputs are set just after a rising edge and held through the next one.
  task automatic cyc(input logic v, input logic d, input logic s);
    v_in = v;
    d_in = d;
    s_in = s;
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    v_in = 1'b0;
    s_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    go_idle();
  endtask

  // lanes[i] is the i-th beat; sync rides on beat 0, gap idles follow beats 0..2.
  task automatic send_frame(input logic [3:0] lanes, input int gap);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, lanes[i], i == 0);
      if (i < 3) repeat (gap) cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    if (FRAME == 5) cyc(1'b1, ^lanes, 1'b0);
    go_idle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    go_idle();
    #1;
    for (int k = 0; k < 2; k++) begin
      check("async_rst_out", k, 8'(out_w[k]), 8'h0);
      check("async_rst_sel", k, 8'(sel_w[k]), 8'h0);
      check("async_rst_ferr", k, 8'(ferr_w[k]), 8'h0);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int v0, f0;

  initial begin
    n_pass = 0;
    n_total = 0;
    vcount = '{0, 0};
    fcount = '{0, 0};
    msb_cfg = '{1'b0, 1'b1};
    syncreq_cfg = '{1'b1, 1'b0};
    rst_n = 1'b0;
    v_in = 1'b0;
    d_in = 1'b0;
    s_in = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Beats 1,0,1,1 with sync first, no gaps.
    v0 = vcount[0];
    send_frame(4'b1101, 0);
    check("lit_valid_lat1", 0, 8'(val_w[0]), 8'h1);
    check("lit_out_1101", 0, 8'(out_w[0]), 8'h0d);
    check("lit_out_msb", 1, 8'(out_w[1]), 8'h0b);
    idle(1);
    check("lit_valid_single", 0, 8'(val_w[0]), 8'h0);

    // Same frame with gaps 3 and 7 cycles.
    send_frame(4'b1101, 3);
    check("lit_gap3_out", 0, 8'(out_w[0]), 8'h0d);
    send_frame(4'b1101, 7);
    check("lit_gap7_out", 0, 8'(out_w[0]), 8'h0d);
    idle(2);
    check("lit_valid_count", 0, 8'(vcount[0] - v0), 8'h3);

    // Sync on the 3rd beat aborts; the sync beat starts the new frame.
    send_frame(4'b0010, 0);
    idle(1);
    check("lit_prime_out", 0, 8'(out_w[0]), 8'h02);
    check("lit_prime_msb", 1, 8'(out_w[1]), 8'h04);
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    go_idle();
    check("lit_ferr", 0, 8'(ferr_w[0]), 8'h1);
    check("lit_ferr", 1, 8'(ferr_w[1]), 8'h1);
    check("lit_out_held", 0, 8'(out_w[0]), 8'h02);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    if (FRAME == 5) cyc(1'b1, 1'b1, 1'b0);
    go_idle();
    check("lit_restart_valid", 0, 8'(val_w[0]), 8'h1);
    check("lit_restart_out", 0, 8'(out_w[0]), 8'h0e);
    check("lit_restart_msb", 1, 8'(out_w[1]), 8'h07);
    idle(2);

    // Reset mid-frame: drop it silently.
    f0 = fcount[0];
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    do_reset();

    // Unsynced beats right after reset: only the SYNC_REQUIRED=0 instance assembles.
    v0 = vcount[0];
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    if (FRAME == 5) cyc(1'b1, 1'b0, 1'b0);
    go_idle();
    check("lit_nosync_valid", 1, 8'(val_w[1]), 8'h1);
    check("lit_nosync_out", 1, 8'(out_w[1]), 8'h06);
    check("lit_hunt_valid", 0, 8'(val_w[0]), 8'h0);
    idle(2);
    check("lit_hunt_count", 0, 8'(vcount[0] - v0), 8'h0);
    check("lit_rst_no_ferr", 0, 8'(fcount[0] - f0), 8'h0);
    send_frame(4'b1101, 0);
    check("lit_post_rst_out", 0, 8'(out_w[0]), 8'h0d);
    idle(1);

`ifdef DEMUX_DESER4_PARITY_EN
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    go_idle();
    check("lit_par_ok_valid", 0, 8'(val_w[0]), 8'h1);
    check("lit_par_ok_out", 0, 8'(out_w[0]), 8'h0b);
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    go_idle();
    check("lit_par_bad_err", 0, 8'(perr_w[0]), 8'h1);
    check("lit_par_bad_valid", 0, 8'(val_w[0]), 8'h0);
    check("lit_par_bad_out", 0, 8'(out_w[0]), 8'h0b);
    idle(1);
`endif

    // Random traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        cyc($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 2);
      end
    end
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/demux_deser4.md
DEMUX_DESER4 -- requirements
Module: demux_deser4

Interface
REQ-001 SHALL have parameter SYNC_REQUIRED, default 1; 1 = discard beats until the first sync_in, 0 = start assembling from reset.
REQ-002 SHALL have parameter MSB_FIRST, default 0; 0 = first beat lands in bit 0, 1 = first beat lands in bit 3.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port demux_in, input, 1 bit: serial data beat.
REQ-006 SHALL have port demux_in_valid, input, 1 bit: demux_in is sampled this cycle.
REQ-007 SHALL have port sync_in, input, 1 bit: qualified by demux_in_valid; marks the beat as the frame's first lane.
REQ-008 SHALL have port demux_sel, output, 2 bits: lane index the next valid beat will fill.
REQ-009 SHALL have port demux_out, output, 4 bits: last completed word, held until the next word completes.
REQ-010 SHALL have port demux_out_valid, output, 1 bit: one-cycle pulse per completed word.
REQ-011 SHALL have port frame_err, output, 1 bit: one-cycle pulse when a frame is aborted.
REQ-012 SHALL have port parity_err, output, 1 bit: one-cycle pulse on parity mismatch.

Function
REQ-013 SHALL implement states HUNT and ASSEMBLE; the reset state is HUNT if SYNC_REQUIRED=1, else ASSEMBLE.
REQ-014 In HUNT, the block SHALL ignore beats without sync; a valid beat with sync SHALL fill lane 0, set demux_sel=1 and enter ASSEMBLE.
REQ-015 In ASSEMBLE, each valid beat SHALL write its lane and advance demux_sel by 1, wrapping 3->0.
REQ-016 Cycles with demux_in_valid=0 SHALL leave demux_sel and the partial word unchanged; gaps are unlimited.
REQ-017 A beat filling lane 3 SHALL cause demux_out to update and demux_out_valid to pulse on the next cycle (latency 1 cycle).
REQ-018 Back-to-back frames SHALL produce back-to-back demux_out_valid pulses with no dead cycle.
REQ-019 A valid beat with sync when demux_sel != 0 SHALL discard the partial word and pulse frame_err one cycle later.
REQ-020 In the case of REQ-019, the sync beat itself SHALL be stored as lane 0, so that frame restarts immediately.
REQ-021 A valid beat with sync when demux_sel = 0 SHALL be normal operation; no error SHALL be raised.
REQ-022 sync_in with demux_in_valid=0 SHALL be ignored.
REQ-023 demux_out SHALL never be modified by a partial or aborted frame.

Reset
REQ-024 On rst_n low, asynchronously: demux_sel=0, demux_out=4'b0000, demux_out_valid=0, frame_err=0, parity_err=0, partial word cleared, state per REQ-013.
REQ-025 A reset asserted mid-frame SHALL drop that frame without raising frame_err.
REQ-026 After reset releases, the first valid beat SHALL be sampled on the first rising clk edge with rst_n high.

Configuration
REQ-027 With macro DEMUX_DESER4_PARITY_EN defined, each frame SHALL carry a fifth beat holding even parity over the 4 data bits; demux_sel SHALL read 0 during the parity beat, tracked by an internal phase flag.
REQ-028 With DEMUX_DESER4_PARITY_EN defined, completion SHALL occur on the parity beat.
REQ-029 With DEMUX_DESER4_PARITY_EN defined and parity matching, demux_out SHALL update and demux_out_valid SHALL pulse.
REQ-030 With DEMUX_DESER4_PARITY_EN defined and parity mismatching, demux_out SHALL hold, demux_out_valid SHALL stay 0, and parity_err SHALL pulse.
REQ-031 With DEMUX_DESER4_PARITY_EN defined, a sync arriving on the parity beat SHALL be treated per REQ-019.
REQ-032 Without DEMUX_DESER4_PARITY_EN, frames SHALL be 4 beats and parity_err SHALL be tied to 0.

Structure
REQ-033 Package demux_deser4_pkg SHALL hold constants LANES=4 and SEL_W=2, and the state enum {HUNT, ASSEMBLE}.
REQ-034 The lane counter and wrap/abort logic SHALL be one sub-module, demux_beat_ctr; all else SHALL be in demux_deser4.

Verification
REQ-035 SYNC_REQUIRED=1, beats 1,0,1,1 with sync on the first beat -> demux_out=4'b1101, one demux_out_valid pulse 1 cycle after the 4th beat.
REQ-036 Same frame with valid gaps of 0, 3 and 7 cycles between beats -> identical output; demux_sel holds during gaps.
REQ-037 Sync on the 3rd beat of a frame -> frame_err pulse, old demux_out held, new frame completes 4 beats after the sync.
REQ-038 Beats before any sync with SYNC_REQUIRED=1 -> no output; with SYNC_REQUIRED=0 -> word completes on the 4th beat after reset.
REQ-039 rst_n pulled low after 2 beats -> all outputs reset immediately; no frame_err; next sync frame decodes correctly.
REQ-040 PARITY_EN: data 1,1,0,1 with parity 1 -> valid, demux_out=4'b1011; same data with parity 0 -> parity_err pulse, no valid, demux_out held.
